// File: rtl/pipe_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_pkg
// Shared definitions for the 5-stage pipeline hazard controller:
//   - operand forwarding source encodings (FWD_REG/FWD_E/FWD_M/FWD_W)
//   - data-memory handshake FSM states (MEMFSM_IDLE/MEMFSM_WAIT)
//   - width of the memory wait counter
// ---------------------------------------------------------------------------
package pipe_hazard_ctrl_pkg;

    localparam int FWD_WIDTH = 2;
    localparam int MEM_CNT_W = 8;

    typedef enum logic [FWD_WIDTH-1:0] {
        FWD_REG = 2'd0,
        FWD_E   = 2'd1,
        FWD_M   = 2'd2,
        FWD_W   = 2'd3
    } fwd_sel_e;

    typedef enum logic {
        MEMFSM_IDLE = 1'b0,
        MEMFSM_WAIT = 1'b1
    } memfsm_e;

endpackage : pipe_hazard_ctrl_pkg

// File: rtl/pipe_hazard_ctrl_sb_entry.sv
// ---------------------------------------------------------------------------
// hazard_sb_entry
// One scoreboard stage register {valid, dst, is_load}.
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset (clears valid)
//   hold_i            keep current contents (highest priority)
//   clr_i             load an empty entry (valid = 0)
//   ld_i              capture valid_i/dst_i/is_load_i
//   valid_i/dst_i/is_load_i   incoming entry
//   valid_o/dst_o/is_load_o   registered entry
// Only the valid bit is reset; dst/is_load are qualified by valid.
// ---------------------------------------------------------------------------
module hazard_sb_entry
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              hold_i,
    input  logic              clr_i,
    input  logic              ld_i,
    input  logic              valid_i,
    input  logic [REG_AW-1:0] dst_i,
    input  logic              is_load_i,
    output logic              valid_o,
    output logic [REG_AW-1:0] dst_o,
    output logic              is_load_o
);

    logic              valid_q, valid_d;
    logic [REG_AW-1:0] dst_q, dst_d;
    logic              is_load_q, is_load_d;

    always_comb begin
        valid_d   = valid_q;
        dst_d     = dst_q;
        is_load_d = is_load_q;
        if (!hold_i) begin
            if (clr_i) begin
                valid_d = 1'b0;
            end else if (ld_i) begin
                valid_d   = valid_i;
                dst_d     = dst_i;
                is_load_d = is_load_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk_i) begin
        dst_q     <= dst_d;
        is_load_q <= is_load_d;
    end

    assign valid_o   = valid_q;
    assign dst_o     = dst_q;
    assign is_load_o = is_load_q;

endmodule : hazard_sb_entry

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Central sequencer for the F/D/E/M/W pipeline: tracks in-flight
// destinations in a 3-entry scoreboard (E, M, W), selects decode operand
// forwarding, raises load-use stalls, applies redirect flushes and freezes
// the pipe while data memory is busy.
//
// Configuration macro: PIPE_FWD_EN
//   defined   : forwarding E > M > W; only loads not yet in W stall.
//   undefined : fwd outputs tied to 0; any match with a valid entry stalls.
//
// Ports:
//   clk_i, rst_i                  clock, asynchronous active-high reset
//   D_valid_i, D_rs1_i, D_rs2_i   decode instruction and source indices
//   D_use_rs1_i, D_use_rs2_i      sources actually read
//   D_need_dstE_i, D_dstE_i       destination write enable and index
//   D_sel_reg_i                   0 = load (result available in W only)
//   E_redirect_i                  taken branch / jump resolved in E
//   M_mem_req_i, M_mem_ack_i      data memory handshake
//   F/D/E/M_stall_o               hold stage registers
//   E_bubble_o, W_bubble_o        insert NOP into D->E / M->W
//   D_flush_o                     kill F->D
//   D_fwdA_o, D_fwdB_o            operand source select
//   M_mem_err_o                   sticky memory timeout flag
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW      = 5,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 D_valid_i,
    input  logic [REG_AW-1:0]    D_rs1_i,
    input  logic [REG_AW-1:0]    D_rs2_i,
    input  logic                 D_use_rs1_i,
    input  logic                 D_use_rs2_i,
    input  logic                 D_need_dstE_i,
    input  logic [REG_AW-1:0]    D_dstE_i,
    input  logic                 D_sel_reg_i,
    input  logic                 E_redirect_i,
    input  logic                 M_mem_req_i,
    input  logic                 M_mem_ack_i,
    output logic                 F_stall_o,
    output logic                 D_stall_o,
    output logic                 E_stall_o,
    output logic                 M_stall_o,
    output logic                 E_bubble_o,
    output logic                 W_bubble_o,
    output logic                 D_flush_o,
    output logic [FWD_WIDTH-1:0] D_fwdA_o,
    output logic [FWD_WIDTH-1:0] D_fwdB_o,
    output logic                 M_mem_err_o
);

    localparam logic [MEM_CNT_W-1:0] TMO = MEM_CNT_W'(MEM_TIMEOUT);

    // Scoreboard taps
    logic              e_v, m_v, w_v;
    logic [REG_AW-1:0] e_dst, m_dst, w_dst;
    logic              e_ld, m_ld, w_ld;

    logic freeze, load_use, e_clr;

    memfsm_e              state_q, state_d;
    logic [MEM_CNT_W-1:0] cnt_q, cnt_d;
    logic                 err_q, err_d;

    function automatic logic hit(input logic en, input logic [REG_AW-1:0] idx,
                                 input logic v, input logic [REG_AW-1:0] dst);
        return en && (idx != '0) && v && (dst == idx);
    endfunction

    function automatic fwd_sel_e pick(input logic he, input logic hm, input logic hw);
        if (he)      return FWD_E;
        else if (hm) return FWD_M;
        else if (hw) return FWD_W;
        else         return FWD_REG;
    endfunction

    logic a_e, a_m, a_w, b_e, b_m, b_w;

    always_comb begin
        a_e = hit(D_use_rs1_i, D_rs1_i, e_v, e_dst);
        a_m = hit(D_use_rs1_i, D_rs1_i, m_v, m_dst);
        a_w = hit(D_use_rs1_i, D_rs1_i, w_v, w_dst);
        b_e = hit(D_use_rs2_i, D_rs2_i, e_v, e_dst);
        b_m = hit(D_use_rs2_i, D_rs2_i, m_v, m_dst);
        b_w = hit(D_use_rs2_i, D_rs2_i, w_v, w_dst);
    end

`ifdef PIPE_FWD_EN
    fwd_sel_e sel_a, sel_b;

    // A load's data only exists from W on, so a youngest match on a load
    // sitting in E or M cannot be forwarded yet.
    always_comb begin
        sel_a    = pick(a_e, a_m, a_w);
        sel_b    = pick(b_e, b_m, b_w);
        load_use = D_valid_i &&
                   (((sel_a == FWD_E) && e_ld) || ((sel_a == FWD_M) && m_ld) ||
                    ((sel_b == FWD_E) && e_ld) || ((sel_b == FWD_M) && m_ld));
    end

    assign D_fwdA_o = sel_a;
    assign D_fwdB_o = sel_b;
`else
    // Without forwarding every in-flight match waits for the regfile write.
    always_comb begin
        load_use = D_valid_i && (a_e || a_m || a_w || b_e || b_m || b_w);
    end

    assign D_fwdA_o = FWD_REG;
    assign D_fwdB_o = FWD_REG;
`endif

    // The pipe freezes from the cycle a request goes unacknowledged until
    // the ack arrives; the ack cycle itself runs normally.
    always_comb begin
        freeze = ((state_q == MEMFSM_IDLE) && M_mem_req_i && !M_mem_ack_i) ||
                 ((state_q == MEMFSM_WAIT) && !M_mem_ack_i);
    end

    // Priority: freeze > redirect > load-use
    assign F_stall_o  = freeze || (load_use && !E_redirect_i);
    assign D_stall_o  = freeze || (load_use && !E_redirect_i);
    assign E_stall_o  = freeze;
    assign M_stall_o  = freeze;
    assign W_bubble_o = freeze;
    assign E_bubble_o = !freeze && (E_redirect_i || load_use);
    assign D_flush_o  = !freeze && E_redirect_i;

    assign e_clr = !(D_valid_i && D_need_dstE_i && (D_dstE_i != '0)) ||
                   E_bubble_o || D_flush_o;

    hazard_sb_entry #(.REG_AW(REG_AW)) u_sb_e (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .hold_i    (freeze),
        .clr_i     (e_clr),
        .ld_i      (1'b1),
        .valid_i   (1'b1),
        .dst_i     (D_dstE_i),
        .is_load_i (!D_sel_reg_i),
        .valid_o   (e_v),
        .dst_o     (e_dst),
        .is_load_o (e_ld)
    );

    hazard_sb_entry #(.REG_AW(REG_AW)) u_sb_m (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .hold_i    (freeze),
        .clr_i     (1'b0),
        .ld_i      (1'b1),
        .valid_i   (e_v),
        .dst_i     (e_dst),
        .is_load_i (e_ld),
        .valid_o   (m_v),
        .dst_o     (m_dst),
        .is_load_o (m_ld)
    );

    hazard_sb_entry #(.REG_AW(REG_AW)) u_sb_w (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .hold_i    (freeze),
        .clr_i     (1'b0),
        .ld_i      (1'b1),
        .valid_i   (m_v),
        .dst_i     (m_dst),
        .is_load_i (m_ld),
        .valid_o   (w_v),
        .dst_o     (w_dst),
        .is_load_o (w_ld)
    );

    // The W load flag is carried for completeness; nothing downstream needs it.
    logic unused_sb;
    assign unused_sb = &{1'b0, w_ld, e_ld, m_ld};

    // Memory handshake FSM with saturating wait counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            MEMFSM_IDLE: begin
                cnt_d = '0;
                if (M_mem_req_i && !M_mem_ack_i) begin
                    state_d = MEMFSM_WAIT;
                end
            end
            MEMFSM_WAIT: begin
                if (M_mem_ack_i) begin
                    state_d = MEMFSM_IDLE;
                    cnt_d   = '0;
                end else begin
                    if (cnt_q != TMO) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (cnt_d == TMO) begin
                        err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = MEMFSM_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= MEMFSM_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign M_mem_err_o = err_q;

endmodule : pipe_hazard_ctrl

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Directed bench for pipe_hazard_ctrl. Each step drives decode/E/M inputs on
// the falling edge, queues the expected output vector and compares it 1 ns
// later. Output vector layout (12 bits):
//   {F_stall, D_stall, E_stall, M_stall, E_bubble, W_bubble, D_flush,
//    D_fwdA[1:0], D_fwdB[1:0], M_mem_err}
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

`ifdef PIPE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       D_valid_i;
    logic [4:0] D_rs1_i, D_rs2_i, D_dstE_i;
    logic       D_use_rs1_i, D_use_rs2_i, D_need_dstE_i, D_sel_reg_i;
    logic       E_redirect_i, M_mem_req_i, M_mem_ack_i;
    logic       F_stall_o, D_stall_o, E_stall_o, M_stall_o;
    logic       E_bubble_o, W_bubble_o, D_flush_o, M_mem_err_o;
    logic [1:0] D_fwdA_o, D_fwdB_o;

    pipe_hazard_ctrl #(.REG_AW(5), .MEM_TIMEOUT(255)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .D_valid_i     (D_valid_i),
        .D_rs1_i       (D_rs1_i),
        .D_rs2_i       (D_rs2_i),
        .D_use_rs1_i   (D_use_rs1_i),
        .D_use_rs2_i   (D_use_rs2_i),
        .D_need_dstE_i (D_need_dstE_i),
        .D_dstE_i      (D_dstE_i),
        .D_sel_reg_i   (D_sel_reg_i),
        .E_redirect_i  (E_redirect_i),
        .M_mem_req_i   (M_mem_req_i),
        .M_mem_ack_i   (M_mem_ack_i),
        .F_stall_o     (F_stall_o),
        .D_stall_o     (D_stall_o),
        .E_stall_o     (E_stall_o),
        .M_stall_o     (M_stall_o),
        .E_bubble_o    (E_bubble_o),
        .W_bubble_o    (W_bubble_o),
        .D_flush_o     (D_flush_o),
        .D_fwdA_o      (D_fwdA_o),
        .D_fwdB_o      (D_fwdB_o),
        .M_mem_err_o   (M_mem_err_o)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;
    logic [11:0] exp_q[$];
    string       tag_q[$];

    localparam logic [11:0] ZERO = 12'h000;

    function automatic logic [11:0] ev(input bit fz, input bit st, input bit eb,
                                       input bit fl, input logic [1:0] fa,
                                       input logic [1:0] fb, input bit er);
        return {fz | st, fz | st, fz, fz, eb, fz, fl, fa, fb, er};
    endfunction

    task automatic expect_out(input string tag, input logic [11:0] e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic check_now();
        logic [11:0] obs, e;
        string       tag;
        obs = {F_stall_o, D_stall_o, E_stall_o, M_stall_o, E_bubble_o,
               W_bubble_o, D_flush_o, D_fwdA_o, D_fwdB_o, M_mem_err_o};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty observed=%03h expected=none", obs);
        end else begin
            e   = exp_q.pop_front();
            tag = tag_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s observed=%03h expected=%03h", tag, obs, e);
            end
        end
    endtask

    task automatic step(input string tag, input logic [11:0] e);
        expect_out(tag, e);
        #1;
        check_now();
        @(negedge clk_i);
    endtask

    task automatic set_d(input bit v, input logic [4:0] rs1, input bit u1,
                         input logic [4:0] rs2, input bit u2, input bit need,
                         input logic [4:0] dst, input bit is_load);
        D_valid_i     = v;
        D_rs1_i       = rs1;
        D_use_rs1_i   = u1;
        D_rs2_i       = rs2;
        D_use_rs2_i   = u2;
        D_need_dstE_i = need;
        D_dstE_i      = dst;
        D_sel_reg_i   = !is_load;
    endtask

    task automatic nop();
        set_d(0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0);
    endtask

    task automatic drain();
        nop();
        for (int i = 0; i < 3; i++) step("drain", ZERO);
    endtask

    initial begin
        int ns;
        rst_i        = 1'b1;
        E_redirect_i = 1'b0;
        M_mem_req_i  = 1'b0;
        M_mem_ack_i  = 1'b0;
        nop();
        #1;
        expect_out("reset", ZERO);
        check_now();
        @(negedge clk_i);
        rst_i = 1'b0;

        // ld x5,0(x1) ; add x6,x5,x1
        set_d(1, 5'd1, 1, 5'd0, 0, 1, 5'd5, 1);
        step("lu_ld", ZERO);
        set_d(1, 5'd5, 1, 5'd1, 1, 1, 5'd6, 0);
        ns = FWD ? 2 : 3;
        for (int k = 0; k < ns; k++)
            step("lu_stall", ev(0, 1, 1, 0, FWD ? 2'(k + 1) : 2'd0, 2'd0, 0));
        step("lu_fwd", ev(0, 0, 0, 0, FWD ? 2'd3 : 2'd0, 2'd0, 0));
        drain();

        // addi x5,x1 ; g gaps ; sub x7,x1,x5
        for (int g = 0; g < 3; g++) begin
            set_d(1, 5'd1, 1, 5'd0, 0, 1, 5'd5, 0);
            step("fw_addi", ZERO);
            nop();
            for (int k = 0; k < g; k++) step("fw_gap", ZERO);
            set_d(1, 5'd1, 1, 5'd5, 1, 1, 5'd7, 0);
            ns = FWD ? 0 : 3 - g;
            for (int k = 0; k < ns; k++) step("fw_stall", ev(0, 1, 1, 0, 2'd0, 2'd0, 0));
            step("fw_sel", ev(0, 0, 0, 0, 2'd0, FWD ? 2'(g + 1) : 2'd0, 0));
            drain();
        end

        // addi x0,x1 ; add x2,x0,x0
        set_d(1, 5'd1, 1, 5'd0, 0, 1, 5'd0, 0);
        step("x0_wr", ZERO);
        set_d(1, 5'd0, 1, 5'd0, 1, 1, 5'd2, 0);
        step("x0_rd", ZERO);
        drain();

        // redirect coincident with load-use
        set_d(1, 5'd1, 1, 5'd0, 0, 1, 5'd5, 1);
        step("rd_ld", ZERO);
        set_d(1, 5'd5, 1, 5'd1, 1, 1, 5'd6, 0);
        E_redirect_i = 1'b1;
        step("redir", ev(0, 0, 1, 1, FWD ? 2'd1 : 2'd0, 2'd0, 0));
        E_redirect_i = 1'b0;
        nop();
        step("redir_after", ZERO);
        drain();

        // memory freeze, ack on the 5th cycle, redirect suppressed while frozen
        set_d(1, 5'd1, 1, 5'd0, 0, 1, 5'd5, 0);
        step("mem_addi", ZERO);
        set_d(1, 5'd1, 1, 5'd5, 1, 1, 5'd7, 0);
        M_mem_req_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            E_redirect_i = (k == 3);
            step("mem_frz", ev(1, 0, 0, 0, 2'd0, FWD ? 2'd1 : 2'd0, 0));
        end
        M_mem_ack_i = 1'b1;
        step("mem_rel", ev(0, 0, 1, 1, 2'd0, FWD ? 2'd1 : 2'd0, 0));
        M_mem_req_i  = 1'b0;
        M_mem_ack_i  = 1'b0;
        E_redirect_i = 1'b0;
        drain();

        // request acked in the same cycle: no freeze
        M_mem_req_i = 1'b1;
        M_mem_ack_i = 1'b1;
        step("mem_fast", ZERO);
        M_mem_req_i = 1'b0;
        M_mem_ack_i = 1'b0;
        step("mem_fast_idle", ZERO);

        // timeout
        M_mem_req_i = 1'b1;
        step("tmo_start", ev(1, 0, 0, 0, 2'd0, 2'd0, 0));
        for (int k = 0; k < 254; k++) @(negedge clk_i);
        step("tmo_pre", ev(1, 0, 0, 0, 2'd0, 2'd0, 0));
        step("tmo_err", ev(1, 0, 0, 0, 2'd0, 2'd0, 1));
        M_mem_ack_i = 1'b1;
        step("tmo_ack", ev(0, 0, 0, 0, 2'd0, 2'd0, 1));
        M_mem_req_i = 1'b0;
        M_mem_ack_i = 1'b0;
        step("tmo_sticky", ev(0, 0, 0, 0, 2'd0, 2'd0, 1));

        // asynchronous reset in WAIT
        M_mem_req_i = 1'b1;
        step("rst_req", ev(1, 0, 0, 0, 2'd0, 2'd0, 1));
        M_mem_req_i = 1'b0;
        #1;
        expect_out("rst_wait", ev(1, 0, 0, 0, 2'd0, 2'd0, 1));
        check_now();
        #1;
        rst_i = 1'b1;
        #1;
        expect_out("rst_async", ZERO);
        check_now();
        @(negedge clk_i);
        rst_i = 1'b0;
        step("rst_idle", ZERO);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_pipe_hazard_ctrl
